ysyx_24090012_mem_arbiter: RTL and testbench
============================================

Name: ysyx_24090012_mem_arbiter

Overview:
- Shares the single ysyx_24090012_SRAM port between the IFU (instruction fetch, read-only) and the LSU (load/store, read/write).
- Sits between the IFU/LSU valid/ready request interfaces and the SRAM slave interface.
- Registers the winning request, holds it on the SRAM until `sram_ready`, and routes the response back to the owner.
- Provides selectable arbitration and a watchdog timeout that returns an error response.

Parameters:
- ARB_MODE, 0: 0 = fixed priority, LSU wins ties; 1 = round-robin between IFU and LSU.
- TIMEOUT, 255: number of GRANT cycles without `sram_ready` before an error response; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_valid  in  1  IFU read request.
- ifu_addr  in  32  IFU fetch address.
- ifu_ready  out  1  one-cycle response pulse to IFU.
- ifu_rdata  out  32  fetched word; valid only while `ifu_ready`.
- ifu_err  out  1  high with `ifu_ready` when the response is a timeout.
- lsu_valid  in  1  LSU request.
- lsu_addr  in  32  LSU address.
- lsu_wdata  in  32  store data.
- lsu_wmask  in  4  byte write mask.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_ready  out  1  one-cycle response pulse to LSU.
- lsu_rdata  out  32  load data; valid only while `lsu_ready`.
- lsu_err  out  1  high with `lsu_ready` on timeout.
- sram_valid  out  1  request to SRAM.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_wmask  out  4  SRAM byte mask.
- sram_wen  out  1  SRAM write enable.
- sram_ready  in  1  SRAM completion pulse.
- sram_rdata  in  32  SRAM read data, valid with `sram_ready`.
- busy  out  1  high when the state is not IDLE.

Behaviour:
- Reset (`rst` high at a clock edge):
  - State = IDLE, `last_grant` = IFU, watchdog counter = 0, request registers = 0.
  - All outputs 0.
  - Reset mid-transaction aborts it: no ready pulse to either master. A `sram_ready` arriving after reset is ignored.
- States: IDLE, GRANT_IFU, GRANT_LSU.
- IDLE:
  - No masters valid: stay in IDLE.
  - Only one master valid: latch its request, go to GRANT_<master>.
  - Both valid, ARB_MODE=0: LSU wins.
  - Both valid, ARB_MODE=1: the master that is not `last_grant` wins.
  - Latching the IFU request captures `sram_wen`=0 and `sram_wmask`=0; `sram_wdata` is don't-care (drive 0).
  - Latching the LSU request captures addr, wdata, wmask and wen.
  - `last_grant` updates to the winner.
  - The counter clears on entry to GRANT.
- GRANT_x:
  - `sram_valid`=1; `sram_addr`/`wdata`/`wmask`/`wen` come from the latched registers and are stable for the whole grant.
  - A master dropping valid mid-grant is ignored; the transaction completes and the ready pulse is still issued.
  - `sram_ready`=1 in GRANT_x: `x_ready`=1 and `x_rdata`=`sram_rdata` in the same cycle (combinational), `x_err`=0. Next state is IDLE.
  - `sram_ready`=0: counter increments (saturating).
  - TIMEOUT≠0 and counter == TIMEOUT-1 with no `sram_ready`: `x_ready`=1, `x_err`=1, `x_rdata`=0 that cycle; `sram_valid` drops next cycle; next state is IDLE.
  - `sram_ready` and timeout in the same cycle: `sram_ready` wins (normal response, err=0).
- Outside the owning grant, `x_ready`, `x_err` and `x_rdata` are 0.
- A `sram_ready` seen in IDLE is ignored.
- Latency: request seen in IDLE at cycle N → `sram_valid` at N+1 → response at the first cycle with `sram_ready` → IDLE the following cycle.
  - Minimum turnaround is 2 cycles; back-to-back grants are separated by one IDLE cycle.
- Masters hold valid until their ready pulse.
  - A master whose valid is still high in IDLE after its ready pulse is treated as a new request.
  - Masters must drop valid the cycle after ready if no new access is intended.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1 bit.
- `busy` = (state != IDLE).

Test Plan:
- Reset then IFU-only read: `ifu_valid`=1, `ifu_addr`=0x80000000; SRAM returns 0x00100073 two cycles after `sram_valid` → `sram_valid` rises 1 cycle after request; `ifu_ready` pulses 1 cycle with `ifu_rdata`=0x00100073, `ifu_err`=0; `sram_wen`=0, `sram_wmask`=0.
- ARB_MODE=0, both valid at once (IFU 0x80000004, LSU write 0x80001000/0xCAFEBABE/mask 0xF) → LSU granted first with exact wdata/mask/wen=1; IFU granted after one IDLE cycle; no overlapping ready pulses.
- ARB_MODE=1, both masters held valid for 4 transactions → grant order LSU, IFU, LSU, IFU.
- TIMEOUT=4, SRAM never readies on an LSU read → `lsu_ready`=1, `lsu_err`=1, `lsu_rdata`=0 on the 4th GRANT cycle; `busy` low 1 cycle later; a stray `sram_ready` afterwards produces no ready pulse.
- `sram_ready` on exactly the TIMEOUT-1 cycle → normal response with `err`=0.
- Reset asserted mid-GRANT_LSU, then `sram_ready` pulses → no `lsu_ready`; all outputs 0; next IFU request is serviced normally.

Source files
------------

// File: rtl/ysyx_24090012_mem_arbiter.sv
// IFU/LSU arbiter for the single SRAM port.
// Registers the winner, holds it until sram_ready or watchdog expiry.
module ysyx_24090012_mem_arbiter #(
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_ready,
  output logic [31:0] ifu_rdata,
  output logic        ifu_err,
  input  logic        lsu_valid,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  input  logic        lsu_wen,
  output logic        lsu_ready,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  output logic        sram_valid,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [3:0]  sram_wmask,
  output logic        sram_wen,
  input  logic        sram_ready,
  input  logic [31:0] sram_rdata,
  output logic        busy
);

  localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] TLIM_C = CW'(TLIM);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_IFU = 2'd1,
    GRANT_LSU = 2'd2
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic          last_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wmask_q;
  logic          wen_q;
  logic          tmo;
  logic          fin;

  // last_q: 1 means the LSU owned the previous grant
  assign tmo = (TIMEOUT != 0) && (cnt_q == TLIM_C) && !sram_ready;
  assign fin = sram_ready || tmo;

  assign busy       = (state_q != IDLE);
  assign sram_valid = busy;
  assign sram_addr  = busy ? addr_q  : '0;
  assign sram_wdata = busy ? wdata_q : '0;
  assign sram_wmask = busy ? wmask_q : '0;
  assign sram_wen   = busy & wen_q;

  // Arbitration, completion and response routing
  always_comb begin
    state_d   = state_q;
    ifu_ready = 1'b0;
    ifu_err   = 1'b0;
    ifu_rdata = '0;
    lsu_ready = 1'b0;
    lsu_err   = 1'b0;
    lsu_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (lsu_valid &&
            (!ifu_valid || ARB_MODE == 0 || !last_q))
          state_d = GRANT_LSU;
        else if (ifu_valid)
          state_d = GRANT_IFU;
      end
      GRANT_IFU: begin
        if (fin) begin
          ifu_ready = 1'b1;
          ifu_err   = tmo;
          ifu_rdata = sram_ready ? sram_rdata : '0;
          state_d   = IDLE;
        end
      end
      GRANT_LSU: begin
        if (fin) begin
          lsu_ready = 1'b1;
          lsu_err   = tmo;
          lsu_rdata = sram_ready ? sram_rdata : '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request latch and watchdog counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && state_d != IDLE) begin
        last_q <= (state_d == GRANT_LSU);
        cnt_q  <= '0;
        if (state_d == GRANT_LSU) begin
          addr_q  <= lsu_addr;
          wdata_q <= lsu_wdata;
          wmask_q <= lsu_wmask;
          wen_q   <= lsu_wen;
        end else begin
          addr_q  <= ifu_addr;
          wdata_q <= '0;
          wmask_q <= '0;
          wen_q   <= 1'b0;
        end
      end else if (state_q != IDLE && !sram_ready &&
                   cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090012_mem_arbiter.sv
// Directed bench for the IFU/LSU SRAM arbiter.
// d0: fixed priority, d1: round-robin; both TIMEOUT=4.
module tb_ysyx_24090012_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [31:0] ifu_addr;
  logic        lsu_valid;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_wen;
  logic        sram_ready;
  logic [31:0] sram_rdata;

  logic        a_iready, a_ierr, a_lready, a_lerr;
  logic [31:0] a_irdata, a_lrdata, a_saddr, a_swdata;
  logic [3:0]  a_swmask;
  logic        a_svalid, a_swen, a_busy;

  logic        b_iready, b_ierr, b_lready, b_lerr;
  logic [31:0] b_irdata, b_lrdata, b_saddr, b_swdata;
  logic [3:0]  b_swmask;
  logic        b_svalid, b_swen, b_busy;

  int nvec;
  int nerr;

  ysyx_24090012_mem_arbiter #(
    .ARB_MODE(0),
    .TIMEOUT (4)
  ) d0 (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_valid),
    .ifu_addr  (ifu_addr),
    .ifu_ready (a_iready),
    .ifu_rdata (a_irdata),
    .ifu_err   (a_ierr),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_wmask (lsu_wmask),
    .lsu_wen   (lsu_wen),
    .lsu_ready (a_lready),
    .lsu_rdata (a_lrdata),
    .lsu_err   (a_lerr),
    .sram_valid(a_svalid),
    .sram_addr (a_saddr),
    .sram_wdata(a_swdata),
    .sram_wmask(a_swmask),
    .sram_wen  (a_swen),
    .sram_ready(sram_ready),
    .sram_rdata(sram_rdata),
    .busy      (a_busy)
  );

  ysyx_24090012_mem_arbiter #(
    .ARB_MODE(1),
    .TIMEOUT (4)
  ) d1 (
    .clk       (clk),
    .rst       (rst),
    .ifu_valid (ifu_valid),
    .ifu_addr  (ifu_addr),
    .ifu_ready (b_iready),
    .ifu_rdata (b_irdata),
    .ifu_err   (b_ierr),
    .lsu_valid (lsu_valid),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_wmask (lsu_wmask),
    .lsu_wen   (lsu_wen),
    .lsu_ready (b_lready),
    .lsu_rdata (b_lrdata),
    .lsu_err   (b_lerr),
    .sram_valid(b_svalid),
    .sram_addr (b_saddr),
    .sram_wdata(b_swdata),
    .sram_wmask(b_swmask),
    .sram_wen  (b_swen),
    .sram_ready(sram_ready),
    .sram_rdata(sram_rdata),
    .busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic exp_lsu [4];

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b0;
    ifu_valid = 1'b0;
    ifu_addr = '0;
    lsu_valid = 1'b0;
    lsu_addr = '0;
    lsu_wdata = '0;
    lsu_wmask = '0;
    lsu_wen = 1'b0;
    sram_ready = 1'b0;
    sram_rdata = '0;
    exp_lsu[0] = 1'b1;
    exp_lsu[1] = 1'b0;
    exp_lsu[2] = 1'b1;
    exp_lsu[3] = 1'b0;

    // reset state
    tick();
    do_reset();
    settle();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_svalid", 32'(a_svalid), 32'd0);
    chk("rst_saddr", a_saddr, 32'd0);
    chk("rst_iready", 32'(a_iready), 32'd0);
    chk("rst_lready", 32'(a_lready), 32'd0);
    chk("rst_b_busy", 32'(b_busy), 32'd0);

    // IFU-only read
    ifu_valid = 1'b1;
    ifu_addr = 32'h8000_0000;
    settle();
    chk("if_idle_sv", 32'(a_svalid), 32'd0);
    tick();
    settle();
    chk("if_sv", 32'(a_svalid), 32'd1);
    chk("if_addr", a_saddr, 32'h8000_0000);
    chk("if_wen", 32'(a_swen), 32'd0);
    chk("if_wmask", 32'(a_swmask), 32'd0);
    chk("if_rdy_early", 32'(a_iready), 32'd0);
    tick();
    settle();
    chk("if_wait_rdy", 32'(a_iready), 32'd0);
    chk("if_wait_sv", 32'(a_svalid), 32'd1);
    tick();
    sram_ready = 1'b1;
    sram_rdata = 32'h0010_0073;
    settle();
    chk("if_rdy", 32'(a_iready), 32'd1);
    chk("if_rdata", a_irdata, 32'h0010_0073);
    chk("if_err", 32'(a_ierr), 32'd0);
    chk("if_lrdy", 32'(a_lready), 32'd0);
    tick();
    ifu_valid = 1'b0;
    sram_ready = 1'b0;
    settle();
    chk("if_done_busy", 32'(a_busy), 32'd0);
    chk("if_done_rdy", 32'(a_iready), 32'd0);
    chk("if_done_rdata", a_irdata, 32'd0);

    // fixed priority: LSU wins the tie
    ifu_valid = 1'b1;
    ifu_addr = 32'h8000_0004;
    lsu_valid = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_wdata = 32'hCAFE_BABE;
    lsu_wmask = 4'hF;
    lsu_wen = 1'b1;
    tick();
    settle();
    chk("pr_l_addr", a_saddr, 32'h8000_1000);
    chk("pr_l_wdata", a_swdata, 32'hCAFE_BABE);
    chk("pr_l_wmask", 32'(a_swmask), 32'hF);
    chk("pr_l_wen", 32'(a_swen), 32'd1);
    sram_ready = 1'b1;
    sram_rdata = 32'h0;
    settle();
    chk("pr_l_rdy", 32'(a_lready), 32'd1);
    chk("pr_l_err", 32'(a_lerr), 32'd0);
    chk("pr_l_irdy", 32'(a_iready), 32'd0);
    tick();
    lsu_valid = 1'b0;
    sram_ready = 1'b0;
    settle();
    chk("pr_gap_busy", 32'(a_busy), 32'd0);
    chk("pr_gap_lrdy", 32'(a_lready), 32'd0);
    tick();
    settle();
    chk("pr_i_addr", a_saddr, 32'h8000_0004);
    chk("pr_i_wen", 32'(a_swen), 32'd0);
    chk("pr_i_wmask", 32'(a_swmask), 32'd0);
    chk("pr_i_wdata", a_swdata, 32'd0);
    sram_ready = 1'b1;
    sram_rdata = 32'h1234_5678;
    settle();
    chk("pr_i_rdy", 32'(a_iready), 32'd1);
    chk("pr_i_rdata", a_irdata, 32'h1234_5678);
    chk("pr_i_lrdy", 32'(a_lready), 32'd0);
    tick();
    ifu_valid = 1'b0;
    sram_ready = 1'b0;
    settle();
    chk("pr_end_busy", 32'(a_busy), 32'd0);

    // round-robin: LSU, IFU, LSU, IFU
    do_reset();
    ifu_valid = 1'b1;
    ifu_addr = 32'h8000_0008;
    lsu_valid = 1'b1;
    lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      sram_ready = 1'b1;
      sram_rdata = 32'h100 + 32'(i);
      settle();
      chk($sformatf("rr%0d_l", i), 32'(b_lready),
          32'(exp_lsu[i]));
      chk($sformatf("rr%0d_i", i), 32'(b_iready),
          32'(!exp_lsu[i]));
      chk($sformatf("rr%0d_wen", i), 32'(b_swen),
          32'(exp_lsu[i]));
      tick();
      sram_ready = 1'b0;
    end
    ifu_valid = 1'b0;
    lsu_valid = 1'b0;
    lsu_wen = 1'b0;
    tick();

    // watchdog expiry on an LSU read
    do_reset();
    lsu_valid = 1'b1;
    lsu_addr = 32'h8000_3000;
    lsu_wen = 1'b0;
    sram_rdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      settle();
      chk($sformatf("to_wait%0d", c), 32'(a_lready), 32'd0);
    end
    tick();
    settle();
    chk("to_rdy", 32'(a_lready), 32'd1);
    chk("to_err", 32'(a_lerr), 32'd1);
    chk("to_rdata", a_lrdata, 32'd0);
    chk("to_sv", 32'(a_svalid), 32'd1);
    tick();
    lsu_valid = 1'b0;
    settle();
    chk("to_busy", 32'(a_busy), 32'd0);
    chk("to_sv_off", 32'(a_svalid), 32'd0);
    sram_ready = 1'b1;
    settle();
    chk("to_stray_l", 32'(a_lready), 32'd0);
    chk("to_stray_i", 32'(a_iready), 32'd0);
    tick();
    sram_ready = 1'b0;

    // sram_ready on the last watchdog cycle wins
    lsu_valid = 1'b1;
    lsu_addr = 32'h8000_3004;
    for (int c = 1; c <= 3; c++) tick();
    tick();
    sram_ready = 1'b1;
    sram_rdata = 32'hA5A5_A5A5;
    settle();
    chk("edge_rdy", 32'(a_lready), 32'd1);
    chk("edge_err", 32'(a_lerr), 32'd0);
    chk("edge_rdata", a_lrdata, 32'hA5A5_A5A5);
    tick();
    lsu_valid = 1'b0;
    sram_ready = 1'b0;

    // reset mid-grant aborts the transaction
    lsu_valid = 1'b1;
    lsu_addr = 32'h8000_4000;
    lsu_wdata = 32'h5555_AAAA;
    lsu_wmask = 4'h3;
    lsu_wen = 1'b1;
    tick();
    settle();
    chk("ab_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lsu_valid = 1'b0;
    lsu_wen = 1'b0;
    sram_ready = 1'b1;
    sram_rdata = 32'h7777_7777;
    settle();
    chk("ab_lrdy", 32'(a_lready), 32'd0);
    chk("ab_lrdata", a_lrdata, 32'd0);
    chk("ab_busy0", 32'(a_busy), 32'd0);
    chk("ab_sv", 32'(a_svalid), 32'd0);
    chk("ab_saddr", a_saddr, 32'd0);
    chk("ab_swdata", a_swdata, 32'd0);
    tick();
    sram_ready = 1'b0;
    settle();
    chk("ab_after", 32'(a_lready), 32'd0);
    ifu_valid = 1'b1;
    ifu_addr = 32'h8000_0010;
    tick();
    settle();
    chk("ab_i_addr", a_saddr, 32'h8000_0010);
    chk("ab_i_wen", 32'(a_swen), 32'd0);
    sram_ready = 1'b1;
    sram_rdata = 32'h0000_0013;
    settle();
    chk("ab_i_rdy", 32'(a_iready), 32'd1);
    chk("ab_i_rdata", a_irdata, 32'h0000_0013);
    tick();
    ifu_valid = 1'b0;
    sram_ready = 1'b0;
    settle();
    chk("ab_end_busy", 32'(a_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
